// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two issue requesters.
// Each requester has one registered response slot with a valid/ready handshake.
module alu_share_arbiter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [5:0]           req_alu_op,
   input  logic [5:0]           req_func3,
   input  logic [1:0]           req_func7,
   input  logic [2*XLEN-1:0]    req_op_a,
   input  logic [2*XLEN-1:0]    req_op_b,
   input  logic [2*TAG_W-1:0]   req_tag,
   output logic [2:0]           alu_op_o,
   output logic [2:0]           alu_func3_o,
   output logic                 alu_func7_o,
   output logic [XLEN-1:0]      alu_a_o,
   output logic [XLEN-1:0]      alu_b_o,
   input  logic [3:0]           alu_ctrl_i,
   input  logic [XLEN-1:0]      alu_result_i,
   output logic [1:0]           rsp_valid,
   input  logic [1:0]           rsp_ready,
   output logic [2*XLEN-1:0]    rsp_data,
   output logic [2*TAG_W-1:0]   rsp_tag,
   output logic [1:0]           rsp_err
);

   logic [1:0]       elig;
   logic [1:0]       grant;
   logic             sel;
   logic             rr_last;
   logic [TAG_W-1:0] sel_tag;

   // A requester may issue only when its slot is free or being drained this cycle.
   always_comb begin
      elig  = req_valid & (~rsp_valid | rsp_ready) & {2{~flush}};
      grant = 2'b00;
      case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready = grant;
   assign sel       = grant[1];

   // Steer the granted request onto the shared ALU; idle inputs are all zero.
   always_comb begin
      alu_op_o    = 3'b000;
      alu_func3_o = 3'b000;
      alu_func7_o = 1'b0;
      alu_a_o     = '0;
      alu_b_o     = '0;
      sel_tag     = '0;
      if (|grant) begin
         alu_op_o    = sel ? req_alu_op[5:3] : req_alu_op[2:0];
         alu_func3_o = sel ? req_func3[5:3]  : req_func3[2:0];
         alu_func7_o = sel ? req_func7[1]    : req_func7[0];
         alu_a_o     = sel ? req_op_a[2*XLEN-1:XLEN]   : req_op_a[XLEN-1:0];
         alu_b_o     = sel ? req_op_b[2*XLEN-1:XLEN]   : req_op_b[XLEN-1:0];
         sel_tag     = sel ? req_tag[2*TAG_W-1:TAG_W]  : req_tag[TAG_W-1:0];
      end
   end

   // Round-robin pointer only moves on an actual grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rr_last <= 1'b1;
      else if (|grant)
         rr_last <= sel;
   end

   // Response slots: load on grant, otherwise drain on ready or flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_err   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
               rsp_valid[i]                <= 1'b1;
               rsp_data[i*XLEN +: XLEN]    <= alu_result_i;
               rsp_tag[i*TAG_W +: TAG_W]   <= sel_tag;
               rsp_err[i]                  <= (alu_ctrl_i == 4'hF);
            end else if (flush || rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; the shared ALU itself is modelled here.
module tb_alu_share_arbiter;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 4;

   logic                clk;
   logic                rstn;
   logic                flush;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [5:0]          req_alu_op;
   logic [5:0]          req_func3;
   logic [1:0]          req_func7;
   logic [2*XLEN-1:0]   req_op_a;
   logic [2*XLEN-1:0]   req_op_b;
   logic [2*TAG_W-1:0]  req_tag;
   logic [2:0]          alu_op_o;
   logic [2:0]          alu_func3_o;
   logic                alu_func7_o;
   logic [XLEN-1:0]     alu_a_o;
   logic [XLEN-1:0]     alu_b_o;
   logic [3:0]          alu_ctrl_i;
   logic [XLEN-1:0]     alu_result_i;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [2*XLEN-1:0]   rsp_data;
   logic [2*TAG_W-1:0]  rsp_tag;
   logic [1:0]          rsp_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] obs_ready;

   // model state: one response slot per requester plus the last winner
   logic        m_valid [2];
   logic [31:0] m_data  [2];
   logic [3:0]  m_tag   [2];
   logic        m_err   [2];
   int          m_last;

   alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_alu_op(req_alu_op), .req_func3(req_func3), .req_func7(req_func7),
      .req_op_a(req_op_a), .req_op_b(req_op_b), .req_tag(req_tag),
      .alu_op_o(alu_op_o), .alu_func3_o(alu_func3_o), .alu_func7_o(alu_func7_o),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_ctrl_i(alu_ctrl_i), .alu_result_i(alu_result_i),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // alu_control: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,F illegal
   function automatic logic [3:0] ctrl_of(input logic [2:0] op, input logic [2:0] f3, input logic f7);
      logic [3:0] c;
      c = 4'h0;
      if (op == 3'b001) c = 4'h1;
      else if (op == 3'b010 || op == 3'b011) begin
         case (f3)
            3'b000: c = (op == 3'b010 && f7) ? 4'h1 : 4'h0;
            3'b001: c = 4'h2;
            3'b010: c = 4'h3;
            3'b011: c = 4'h4;
            3'b100: c = 4'h5;
            3'b101: c = f7 ? 4'h7 : 4'h6;
            3'b110: c = 4'h8;
            default: c = 4'h9;
         endcase
         if (op == 3'b010 && f7 && f3 != 3'b000 && f3 != 3'b101) c = 4'hF;
      end
      return c;
   endfunction

   function automatic logic [31:0] res_of(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a << b[4:0];
         4'h3: return {31'b0, $signed(a) < $signed(b)};
         4'h4: return {31'b0, a < b};
         4'h5: return a ^ b;
         4'h6: return a >> b[4:0];
         4'h7: return $unsigned($signed(a) >>> b[4:0]);
         4'h8: return a | b;
         4'h9: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      alu_ctrl_i   = ctrl_of(alu_op_o, alu_func3_o, alu_func7_o);
      alu_result_i = res_of(alu_ctrl_i, alu_a_o, alu_b_o);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg);
      req_alu_op[i*3 +: 3] = op;
      req_func3[i*3 +: 3]  = f3;
      req_func7[i]         = f7;
      req_op_a[i*32 +: 32] = a;
      req_op_b[i*32 +: 32] = b;
      req_tag[i*4 +: 4]    = tg;
   endtask

   task automatic rand_req(input int i);
      logic [2:0] ops [4];
      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011;
      set_req(i, ops[$urandom_range(0, 3)], 3'($urandom), 1'($urandom),
              ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 40)),
              ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 40)),
              4'($urandom));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0; m_data[i] = '0; m_tag[i] = '0; m_err[i] = 1'b0;
      end
      m_last = 1;
   endtask

   // One clock: check slots, apply inputs, check grant/steering, advance model.
   task automatic cyc(input logic [1:0] v, input logic [1:0] rr, input logic fl);
      int         q[$];
      int         g;
      logic [1:0] exp_g;
      logic [2:0] eop, ef3;
      logic       ef7;
      logic [31:0] ea, eb;
      logic [3:0] c;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(m_valid[i]));
         check($sformatf("rsp_data%0d", i), 64'(rsp_data[i*32 +: 32]), 64'(m_data[i]));
         check($sformatf("rsp_tag%0d", i), 64'(rsp_tag[i*4 +: 4]), 64'(m_tag[i]));
         check($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(m_err[i]));
      end
      req_valid = v; rsp_ready = rr; flush = fl;
      #1;
      for (int i = 0; i < 2; i++)
         if (v[i] && (!m_valid[i] || rr[i]) && !fl) q.push_back(i);
      g = -1;
      if (q.size() == 1) g = q[0];
      else if (q.size() == 2) g = (m_last == 0) ? 1 : 0;
      exp_g = (g < 0) ? 2'b00 : 2'(2'b01 << g);
      obs_ready = req_ready;
      check("req_ready", 64'(req_ready), 64'(exp_g));
      eop = '0; ef3 = '0; ef7 = 1'b0; ea = '0; eb = '0;
      if (g >= 0) begin
         eop = req_alu_op[g*3 +: 3]; ef3 = req_func3[g*3 +: 3]; ef7 = req_func7[g];
         ea  = req_op_a[g*32 +: 32]; eb = req_op_b[g*32 +: 32];
      end
      check("alu_op", 64'(alu_op_o), 64'(eop));
      check("alu_f3", 64'(alu_func3_o), 64'(ef3));
      check("alu_f7", 64'(alu_func7_o), 64'(ef7));
      check("alu_a", 64'(alu_a_o), 64'(ea));
      check("alu_b", 64'(alu_b_o), 64'(eb));
      for (int i = 0; i < 2; i++)
         if (fl || (i != g && rr[i])) m_valid[i] = 1'b0;
      if (g >= 0) begin
         c = ctrl_of(eop, ef3, ef7);
         m_valid[g] = 1'b1;
         m_data[g]  = res_of(c, ea, eb);
         m_tag[g]   = req_tag[g*4 +: 4];
         m_err[g]   = (c == 4'hF);
         m_last     = g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = '0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held;
      req_alu_op = '0; req_func3 = '0; req_func7 = '0;
      req_op_a = '0; req_op_b = '0; req_tag = '0;
      do_reset();
      check("reset_valid", 64'(rsp_valid), 64'(0));
      check("reset_data", 64'(rsp_data), 64'(0));

      // single requester add, one-cycle latency
      set_req(0, 3'b010, 3'b000, 1'b0, 32'd5, 32'd3, 4'd7);
      cyc(2'b01, 2'b00, 1'b0);
      check("t1_ready", 64'(obs_ready), 64'(2'b01));
      check("t1_valid", 64'(rsp_valid), 64'(2'b01));
      check("t1_data", 64'(rsp_data[31:0]), 64'(32'd8));
      check("t1_tag", 64'(rsp_tag[3:0]), 64'(4'd7));
      check("t1_err", 64'(rsp_err), 64'(0));
      cyc(2'b00, 2'b11, 1'b0);

      // alternating grants under continuous contention
      do_reset();
      for (int k = 0; k < 4; k++) begin
         rand_req(0); rand_req(1);
         cyc(2'b11, 2'b11, 1'b0);
         check("t2_grant", 64'(obs_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      end
      cyc(2'b00, 2'b11, 1'b0);

      // backpressured slot 0 blocks r0 only
      do_reset();
      rand_req(0);
      cyc(2'b01, 2'b00, 1'b0);
      held = m_data[0];
      for (int k = 0; k < 3; k++) begin
         rand_req(0); rand_req(1);
         cyc(2'b11, 2'b10, 1'b0);
         check("t3_r1", 64'(obs_ready), 64'(2'b10));
      end
      check("t3_hold", 64'(rsp_data[31:0]), 64'(held));
      cyc(2'b11, 2'b11, 1'b0);
      check("t3_r0", 64'(obs_ready), 64'(2'b01));
      cyc(2'b00, 2'b11, 1'b0);

      // illegal op flags error; ADDI 10 + -3
      do_reset();
      set_req(1, 3'b010, 3'b001, 1'b1, 32'd9, 32'd4, 4'd3);
      set_req(0, 3'b011, 3'b000, 1'b0, 32'd10, 32'hFFFF_FFFD, 4'd5);
      cyc(2'b11, 2'b00, 1'b0);
      cyc(2'b11, 2'b00, 1'b0);
      check("t4_err", 64'(rsp_err), 64'(2'b10));
      check("t4_data", 64'(rsp_data[31:0]), 64'(32'd7));
      check("t4_valid", 64'(rsp_valid), 64'(2'b11));

      // flush: no grant, slots drop, pointer holds
      cyc(2'b11, 2'b11, 1'b1);
      check("t5_ready", 64'(obs_ready), 64'(2'b00));
      check("t5_valid", 64'(rsp_valid), 64'(2'b00));
      cyc(2'b11, 2'b11, 1'b0);
      check("t5_rr", 64'(obs_ready), 64'(2'b01));
      cyc(2'b00, 2'b11, 1'b0);

      // async reset between edges
      rand_req(0); rand_req(1);
      cyc(2'b01, 2'b00, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
      check("t6_pre", 64'(rsp_valid), 64'(2'b11));
      #2 rstn = 1'b0;
      #1;
      check("t6_valid", 64'(rsp_valid), 64'(2'b00));
      check("t6_data", 64'(rsp_data), 64'(0));
      model_reset();
      req_valid = '0; rsp_ready = '0;
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      rand_req(0); rand_req(1);
      cyc(2'b11, 2'b11, 1'b0);
      check("t6_first", 64'(obs_ready), 64'(2'b01));

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         rand_req(0); rand_req(1);
         cyc(2'($urandom), 2'($urandom), ($urandom_range(0, 11) == 0));
      end
      cyc(2'b00, 2'b00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
